// File: rtl/ascon_permutation_sequencer.sv
// ASCON permutation sequencer: steps the round datapath one round per cycle
// for p^a / p^b and drives round index, state mux select and state enable.
//
// Ports:
//   clock_i, reset_i : clock, synchronous active-high reset
//   start_i, mode_i  : permutation request (0 = p^a, 1 = p^b), ready_o handshake
//   round_o          : round index to the constant-addition stage
//   sel_state_o      : 0 = external state, 1 = state-register feedback
//   en_state_o       : state-register load enable
//   first_round_o    : cycle computes the first round
//   last_round_o     : cycle computes round 11
//   done_o           : permuted state valid on the state register
module ascon_permutation_sequencer #(
  parameter int ROUNDS_A = 12,
  parameter int ROUNDS_B = 6
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       mode_i,
  output logic       ready_o,
  output logic [3:0] round_o,
  output logic       sel_state_o,
  output logic       en_state_o,
  output logic       first_round_o,
  output logic       last_round_o,
  output logic       done_o
);

  if (ROUNDS_A < 1 || ROUNDS_A > 12) begin : g_bad_a
    $fatal(1, "ROUNDS_A must be in 1..12");
  end
  if (ROUNDS_B < 1 || ROUNDS_B > ROUNDS_A) begin : g_bad_b
    $fatal(1, "ROUNDS_B must be in 1..ROUNDS_A");
  end

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] START_A = 4'(12 - ROUNDS_A);
  localparam logic [3:0] START_B = 4'(12 - ROUNDS_B);
  localparam logic [3:0] LAST    = 4'd11;

  logic [1:0] state_q;
  logic [1:0] state_d;
  logic [3:0] cnt_q;
  logic [3:0] cnt_d;
  logic [3:0] start_round;

  // The counter alone carries the latched mode: it starts at the
  // mode's first round and always runs up to LAST.
  assign start_round = mode_i ? START_B : START_A;

  always_comb begin
    state_d       = IDLE;
    cnt_d         = 4'd0;
    ready_o       = 1'b0;
    round_o       = 4'd0;
    sel_state_o   = 1'b0;
    en_state_o    = 1'b0;
    first_round_o = 1'b0;
    last_round_o  = 1'b0;
    done_o        = 1'b0;

    unique case (1'b1)
      (state_q == IDLE): begin
        ready_o = 1'b1;
        round_o = start_round;
      end
      (state_q == DONE): begin
        ready_o     = 1'b1;
        round_o     = start_round;
        sel_state_o = 1'b1;
        done_o      = 1'b1;
      end
      (state_q == RUN): begin
        sel_state_o = 1'b1;
        en_state_o  = 1'b1;
        round_o     = cnt_q;
        if (cnt_q >= LAST) begin
          last_round_o = 1'b1;
          state_d      = DONE;
        end else begin
          state_d = RUN;
          cnt_d   = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Acceptance is identical from IDLE and DONE: the first round
    // always runs on the external state.
    if (ready_o && start_i) begin
      sel_state_o   = 1'b0;
      en_state_o    = 1'b1;
      first_round_o = 1'b1;
      if (start_round >= LAST) begin
        last_round_o = 1'b1;
        state_d      = DONE;
      end else begin
        state_d = RUN;
        cnt_d   = start_round + 4'd1;
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ascon_permutation_sequencer.sv
// Directed testbench for ascon_permutation_sequencer: default build plus
// a ROUNDS_B=1 build for the single-round corner case.
module tb_ascon_permutation_sequencer;

  logic       clk = 1'b0;
  logic       reset_i;
  logic       start_i;
  logic       mode_i;
  logic       ready_o;
  logic [3:0] round_o;
  logic       sel_state_o;
  logic       en_state_o;
  logic       first_round_o;
  logic       last_round_o;
  logic       done_o;

  logic       start1;
  logic       mode1;
  logic       ready1;
  logic [3:0] round1;
  logic       sel1;
  logic       en1;
  logic       first1;
  logic       last1;
  logic       done1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ascon_permutation_sequencer dut (
    .clock_i      (clk),
    .reset_i      (reset_i),
    .start_i      (start_i),
    .mode_i       (mode_i),
    .ready_o      (ready_o),
    .round_o      (round_o),
    .sel_state_o  (sel_state_o),
    .en_state_o   (en_state_o),
    .first_round_o(first_round_o),
    .last_round_o (last_round_o),
    .done_o       (done_o)
  );

  ascon_permutation_sequencer #(
    .ROUNDS_A(12),
    .ROUNDS_B(1)
  ) dut1 (
    .clock_i      (clk),
    .reset_i      (reset_i),
    .start_i      (start1),
    .mode_i       (mode1),
    .ready_o      (ready1),
    .round_o      (round1),
    .sel_state_o  (sel1),
    .en_state_o   (en1),
    .first_round_o(first1),
    .last_round_o (last1),
    .done_o       (done1)
  );

  typedef struct {
    logic       start;
    logic       mode;
    logic [9:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[$];

  // packed as {ready, round[3:0], sel, en, first, last, done}
  function automatic logic [9:0] pk(logic r, int rnd, logic s, logic e,
                                    logic f, logic l, logic d);
    return {r, 4'(rnd), s, e, f, l, d};
  endfunction

  function automatic void mk(string nm, logic st, logic md, logic r, int rnd,
                             logic s, logic e, logic f, logic l, logic d);
    vec_t v;
    v.start = st;
    v.mode  = md;
    v.exp   = pk(r, rnd, s, e, f, l, d);
    v.name  = nm;
    vecs.push_back(v);
  endfunction

  function automatic logic [9:0] act0();
    return {ready_o, round_o, sel_state_o, en_state_o,
            first_round_o, last_round_o, done_o};
  endfunction

  function automatic logic [9:0] act1();
    return {ready1, round1, sel1, en1, first1, last1, done1};
  endfunction

  task automatic chk(string nm, logic [9:0] act, logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b required %b (ready,round,sel,en,first,last,done)",
               nm, act, exp);
    end
  endtask

  task automatic chk_int(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  initial begin
    int n;
    int ens;
    int dones;
    bit seen;

    reset_i = 1'b1;
    start_i = 1'b0;
    mode_i  = 1'b0;
    start1  = 1'b0;
    mode1   = 1'b0;

    // reset state
    mk("reset", 0, 0, 1, 0, 0, 0, 0, 0, 0);
    // p^a single start pulse
    mk("pa_r0", 1, 0, 1, 0, 0, 1, 1, 0, 0);
    for (int k = 1; k <= 11; k++)
      mk($sformatf("pa_r%0d", k), 0, 0, 0, k, 1, 1, 0, k == 11, 0);
    mk("pa_done", 0, 0, 1, 0, 1, 0, 0, 0, 1);
    mk("pa_idle", 0, 0, 1, 0, 0, 0, 0, 0, 0);
    // p^b, start held and mode toggled in RUN, restart in DONE
    mk("pb_r6", 1, 1, 1, 6, 0, 1, 1, 0, 0);
    for (int k = 7; k <= 11; k++)
      mk($sformatf("pb_hold_r%0d", k), 1, k[0], 0, k, 1, 1, 0, k == 11, 0);
    mk("pb_restart", 1, 1, 1, 6, 0, 1, 1, 0, 1);
    for (int k = 7; k <= 11; k++)
      mk($sformatf("pb2_r%0d", k), 0, k[0], 0, k, 1, 1, 0, k == 11, 0);
    mk("pb2_done", 0, 1, 1, 6, 1, 0, 0, 0, 1);
    mk("pb2_idle", 0, 0, 1, 0, 0, 0, 0, 0, 0);
    // p^a, start held and mode toggled, restart into p^a
    mk("pa3_r0", 1, 0, 1, 0, 0, 1, 1, 0, 0);
    for (int k = 1; k <= 11; k++)
      mk($sformatf("pa3_hold_r%0d", k), 1, k[0], 0, k, 1, 1, 0, k == 11, 0);
    mk("pa3_restart", 1, 0, 1, 0, 0, 1, 1, 0, 1);
    for (int k = 1; k <= 11; k++)
      mk($sformatf("pa4_r%0d", k), 0, 1, 0, k, 1, 1, 0, k == 11, 0);
    mk("pa4_done", 0, 0, 1, 0, 1, 0, 0, 0, 1);
    mk("pa4_idle", 0, 0, 1, 0, 0, 0, 0, 0, 0);

    repeat (2) @(posedge clk);
    #1 reset_i = 1'b0;

    foreach (vecs[i]) begin
      start_i = vecs[i].start;
      mode_i  = vecs[i].mode;
      @(negedge clk);
      chk(vecs[i].name, act0(), vecs[i].exp);
      @(posedge clk);
      #1;
    end
    start_i = 1'b0;
    mode_i  = 1'b0;

    // reset at round 5 of p^a
    start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (round_o == 4'd5 && en_state_o) seen = 1'b1;
    end
    chk_int("reach_round5", int'(seen), 1);
    reset_i = 1'b1;
    @(posedge clk);
    #1 reset_i = 1'b0;
    @(negedge clk);
    chk("after_reset", act0(), pk(1, 0, 0, 0, 0, 0, 0));
    dones = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (done_o) dones++;
    end
    chk_int("no_done_after_reset", dones, 0);

    // fresh full p^a: latency and enable count
    @(posedge clk);
    #1 start_i = 1'b1;
    @(negedge clk);
    ens = int'(en_state_o);
    @(posedge clk);
    #1 start_i = 1'b0;
    n = 1;
    seen = 1'b0;
    while (n < 30 && !seen) begin
      @(negedge clk);
      if (done_o) seen = 1'b1;
      else begin
        if (en_state_o) ens++;
        @(posedge clk);
        n++;
      end
    end
    chk_int("fresh_pa_latency", n, 12);
    chk_int("fresh_pa_enables", ens, 12);

    // ROUNDS_B=1 build
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rb1_idle", act1(), pk(1, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1 start1 = 1'b1;
    mode1 = 1'b1;
    @(negedge clk);
    chk("rb1_single", act1(), pk(1, 11, 0, 1, 1, 1, 0));
    @(posedge clk);
    #1 start1 = 1'b1;
    @(negedge clk);
    chk("rb1_done_restart", act1(), pk(1, 11, 0, 1, 1, 1, 1));
    @(posedge clk);
    #1 start1 = 1'b0;
    @(negedge clk);
    chk("rb1_done", act1(), pk(1, 11, 1, 0, 0, 0, 1));
    @(posedge clk);
    #1 mode1 = 1'b0;
    @(negedge clk);
    chk("rb1_back_idle", act1(), pk(1, 0, 0, 0, 0, 0, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
